wb_sram_byte_en_bridge: RTL and testbench



---
 rtl/wb_sram_byte_en_bridge.sv | 203 ++++++++++++++++++++
 tb/tb_wb_sram_byte_en_bridge.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_byte_en_bridge.sv
// wb_sram_byte_en_bridge
//   Wishbone classic slave in front of a byte-enable SRAM with a registered
//   (1-cycle) read port. Narrow Wishbone accesses are steered onto one lane of
//   a wide SRAM line. A single-line read buffer serves repeated reads to the
//   same line without an SRAM cycle. Writes go straight through to the SRAM
//   and are also merged into the buffer when they hit the buffered line.
//
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_wb_adr/dat/sel/we    Wishbone byte address, write data, byte selects, write
//   i_wb_cyc, i_wb_stb     Wishbone cycle / strobe
//   o_wb_dat               read data, valid while o_wb_ack is high
//   o_wb_ack, o_wb_err     one-cycle acknowledge / error
//   o_sram_*               registered SRAM address, write data, write enable,
//                          byte enables
//   i_sram_read_data       SRAM read data (one cycle after the address)
module wb_sram_byte_en_bridge #(
  parameter int unsigned WB_AWIDTH          = 32,
  parameter int unsigned WB_DWIDTH          = 32,
  parameter int unsigned SRAM_ADDRESS_WIDTH = 7,
  parameter int unsigned SRAM_DATA_WIDTH    = 128
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [WB_AWIDTH-1:0]            i_wb_adr,
  input  logic [WB_DWIDTH-1:0]            i_wb_dat,
  input  logic [WB_DWIDTH/8-1:0]          i_wb_sel,
  input  logic                            i_wb_we,
  input  logic                            i_wb_cyc,
  input  logic                            i_wb_stb,
  output logic [WB_DWIDTH-1:0]            o_wb_dat,
  output logic                            o_wb_ack,
  output logic                            o_wb_err,
  output logic [SRAM_ADDRESS_WIDTH-1:0]   o_sram_address,
  output logic [SRAM_DATA_WIDTH-1:0]      o_sram_write_data,
  output logic                            o_sram_write_enable,
  output logic [SRAM_DATA_WIDTH/8-1:0]    o_sram_byte_enable,
  input  logic [SRAM_DATA_WIDTH-1:0]      i_sram_read_data
);

  localparam int unsigned WB_BYTES   = WB_DWIDTH / 8;
  localparam int unsigned SRAM_BYTES = SRAM_DATA_WIDTH / 8;
  localparam int unsigned NUM_LANES  = SRAM_DATA_WIDTH / WB_DWIDTH;
  localparam int unsigned LINE_SHIFT = $clog2(SRAM_BYTES);
  localparam int unsigned LANE_SHIFT = $clog2(WB_BYTES);
  localparam int unsigned LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned RANGE_BIT  = LINE_SHIFT + SRAM_ADDRESS_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ACK,
    S_RD_WAIT,
    S_RD_CAP,
    S_RD_ACK,
    S_ERR
  } state_t;

  state_t                          state_q, state_d;

  logic [SRAM_DATA_WIDTH-1:0]      buf_q, buf_d;
  logic                            buf_valid_q, buf_valid_d;
  logic [SRAM_ADDRESS_WIDTH-1:0]   buf_tag_q, buf_tag_d;
  logic [LANE_W-1:0]               lane_q, lane_d;

  logic [WB_DWIDTH-1:0]            wb_dat_d;
  logic                            wb_ack_d;
  logic                            wb_err_d;
  logic [SRAM_ADDRESS_WIDTH-1:0]   sram_address_d;
  logic [SRAM_DATA_WIDTH-1:0]      sram_write_data_d;
  logic                            sram_write_enable_d;
  logic [SRAM_BYTES-1:0]           sram_byte_enable_d;

  // Request decode
  logic                            req_c;
  logic                            req_oor_c;
  logic                            req_hit_c;
  logic [LANE_W-1:0]               req_lane_c;
  logic [SRAM_ADDRESS_WIDTH-1:0]   req_line_c;
  logic [SRAM_BYTES-1:0]           req_be_c;
  logic [SRAM_DATA_WIDTH-1:0]      req_wdata_c;
  logic [SRAM_DATA_WIDTH-1:0]      merged_buf_c;

  always_comb begin
    req_c       = i_wb_cyc & i_wb_stb;
    req_lane_c  = LANE_W'(i_wb_adr >> LANE_SHIFT) & LANE_W'(NUM_LANES - 1);
    req_line_c  = SRAM_ADDRESS_WIDTH'(i_wb_adr >> LINE_SHIFT);
    req_oor_c   = |(i_wb_adr >> RANGE_BIT);
    req_hit_c   = buf_valid_q && (buf_tag_q == req_line_c);
    req_be_c    = SRAM_BYTES'(i_wb_sel) << (32'(req_lane_c) * WB_BYTES);
    req_wdata_c = {NUM_LANES{i_wb_dat}};
  end

  // Buffer image after a write-through merge of the selected bytes
  always_comb begin
    merged_buf_c = buf_q;
    for (int unsigned b = 0; b < SRAM_BYTES; b++) begin
      if (req_be_c[b]) begin
        merged_buf_c[b*8 +: 8] = req_wdata_c[b*8 +: 8];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d             = state_q;
    buf_d               = buf_q;
    buf_valid_d         = buf_valid_q;
    buf_tag_d           = buf_tag_q;
    lane_d              = lane_q;
    wb_dat_d            = '0;
    wb_ack_d            = 1'b0;
    wb_err_d            = 1'b0;
    sram_address_d      = o_sram_address;
    sram_write_data_d   = o_sram_write_data;
    sram_write_enable_d = 1'b0;
    sram_byte_enable_d  = o_sram_byte_enable;

    case (state_q)
      S_IDLE: begin
        if (req_c) begin
          if (req_oor_c) begin
            wb_err_d = 1'b1;
            state_d  = S_ERR;
          end else if (i_wb_we) begin
            sram_address_d      = req_line_c;
            sram_write_data_d   = req_wdata_c;
            sram_byte_enable_d  = req_be_c;
            sram_write_enable_d = 1'b1;
            wb_ack_d            = 1'b1;
            if (req_hit_c) begin
              buf_d = merged_buf_c;
            end
            state_d = S_WR_ACK;
          end else if (req_hit_c) begin
            wb_dat_d = buf_q[32'(req_lane_c) * WB_DWIDTH +: WB_DWIDTH];
            wb_ack_d = 1'b1;
            state_d  = S_RD_ACK;
          end else begin
            sram_address_d = req_line_c;
            lane_d         = req_lane_c;
            state_d        = S_RD_WAIT;
          end
        end
      end

      // Ack already presented; SRAM captures the write on this edge
      S_WR_ACK: state_d = S_IDLE;

      // SRAM samples the address on this edge
      S_RD_WAIT: state_d = S_RD_CAP;

      // Line is on i_sram_read_data: fill the buffer even if the master left
      S_RD_CAP: begin
        buf_d       = i_sram_read_data;
        buf_valid_d = 1'b1;
        buf_tag_d   = o_sram_address;
        if (i_wb_cyc) begin
          wb_dat_d = i_sram_read_data[32'(lane_q) * WB_DWIDTH +: WB_DWIDTH];
          wb_ack_d = 1'b1;
          state_d  = S_RD_ACK;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_RD_ACK: state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, buffer and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q             <= S_IDLE;
      buf_q               <= '0;
      buf_valid_q         <= 1'b0;
      buf_tag_q           <= '0;
      lane_q              <= '0;
      o_wb_dat            <= '0;
      o_wb_ack            <= 1'b0;
      o_wb_err            <= 1'b0;
      o_sram_address      <= '0;
      o_sram_write_data   <= '0;
      o_sram_write_enable <= 1'b0;
      o_sram_byte_enable  <= '0;
    end else begin
      state_q             <= state_d;
      buf_q               <= buf_d;
      buf_valid_q         <= buf_valid_d;
      buf_tag_q           <= buf_tag_d;
      lane_q              <= lane_d;
      o_wb_dat            <= wb_dat_d;
      o_wb_ack            <= wb_ack_d;
      o_wb_err            <= wb_err_d;
      o_sram_address      <= sram_address_d;
      o_sram_write_data   <= sram_write_data_d;
      o_sram_write_enable <= sram_write_enable_d;
      o_sram_byte_enable  <= sram_byte_enable_d;
    end
  end

endmodule

// File: tb/tb_wb_sram_byte_en_bridge.sv
// Directed bench for wb_sram_byte_en_bridge with a small byte-enable SRAM
// model (registered read, byte-masked write) attached to the SRAM pins.
module tb_wb_sram_byte_en_bridge;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   wb_adr;
  logic [31:0]   wb_dat_w;
  logic [3:0]    wb_sel;
  logic          wb_we;
  logic          wb_cyc;
  logic          wb_stb;
  logic [31:0]   wb_dat_r;
  logic          wb_ack;
  logic          wb_err;
  logic [6:0]    sram_addr;
  logic [127:0]  sram_wdata;
  logic          sram_we;
  logic [15:0]   sram_be;
  logic [127:0]  sram_rdata;

  logic [127:0]  mem [0:127];
  logic          mem_init;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_sram_byte_en_bridge dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_wb_adr            (wb_adr),
    .i_wb_dat            (wb_dat_w),
    .i_wb_sel            (wb_sel),
    .i_wb_we             (wb_we),
    .i_wb_cyc            (wb_cyc),
    .i_wb_stb            (wb_stb),
    .o_wb_dat            (wb_dat_r),
    .o_wb_ack            (wb_ack),
    .o_wb_err            (wb_err),
    .o_sram_address      (sram_addr),
    .o_sram_write_data   (sram_wdata),
    .o_sram_write_enable (sram_we),
    .o_sram_byte_enable  (sram_be),
    .i_sram_read_data    (sram_rdata)
  );

  // Line i, lane L initially holds 0xD000_0000 | (i << 8) | L
  function automatic logic [127:0] pat(input int i);
    logic [127:0] v;
    for (int l = 0; l < 4; l++) begin
      v[l*32 +: 32] = 32'hD000_0000 | (32'(i) << 8) | 32'(l);
    end
    return v;
  endfunction

  // SRAM model: registered read of the old contents, byte-masked write
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= pat(i);
    end else if (sram_we) begin
      for (int b = 0; b < 16; b++) begin
        if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end
    end
    sram_rdata <= mem[sram_addr];
  end

  task automatic drive_req(input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic we);
    wb_adr   = adr;
    wb_dat_w = dat;
    wb_sel   = sel;
    wb_we    = we;
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
  endtask

  // Wait up to 8 edges for ack/err; n is the edge count (1 = first edge), 0 on timeout
  task automatic wait_resp(output int n, output logic a, output logic e,
                           output logic [31:0] d);
    n = 0; a = 1'b0; e = 1'b0; d = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (wb_ack || wb_err) begin
        n = i; a = wb_ack; e = wb_err; d = wb_dat_r;
        break;
      end
    end
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
  endtask

  task automatic test_reset;
    wb_adr = '0; wb_dat_w = '0; wb_sel = '0; wb_we = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    mem_init = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    rst = 1'b0;
    total++; if ({wb_ack, wb_err, sram_we} !== 3'b000) begin bad++;
      $display("FAIL reset_flags: got %b want 000", {wb_ack, wb_err, sram_we}); end
    total++; if (wb_dat_r !== 32'h0) begin bad++;
      $display("FAIL reset_wb_dat: got %h want 0", wb_dat_r); end
    total++; if (sram_addr !== 7'h0) begin bad++;
      $display("FAIL reset_sram_addr: got %h want 0", sram_addr); end
    total++; if (sram_be !== 16'h0) begin bad++;
      $display("FAIL reset_sram_be: got %h want 0", sram_be); end
    total++; if (sram_wdata !== 128'h0) begin bad++;
      $display("FAIL reset_sram_wdata: got %h want 0", sram_wdata); end
  endtask

  task automatic test_write;
    int n; logic a, e; logic [31:0] d;
    drive_req(32'h24, 32'h1122_3344, 4'hF, 1'b1);
    wait_resp(n, a, e, d);
    total++; if (n !== 1 || a !== 1'b1) begin bad++;
      $display("FAIL wr_ack_latency: got n=%0d ack=%b want n=1 ack=1", n, a); end
    total++; if (sram_addr !== 7'd2) begin bad++;
      $display("FAIL wr_sram_addr: got %h want 2", sram_addr); end
    total++; if (sram_be !== 16'h00F0) begin bad++;
      $display("FAIL wr_sram_be: got %h want 00f0", sram_be); end
    total++; if (sram_we !== 1'b1) begin bad++;
      $display("FAIL wr_we_high: got %b want 1", sram_we); end
    total++; if (sram_wdata !== {4{32'h1122_3344}}) begin bad++;
      $display("FAIL wr_sram_wdata: got %h want 4x11223344", sram_wdata); end
    @(posedge clk); #1;
    total++; if ({sram_we, wb_ack} !== 2'b00) begin bad++;
      $display("FAIL wr_one_cycle: got we/ack=%b want 00", {sram_we, wb_ack}); end
    total++; if (mem[2] !== 128'hD000_0203_D000_0202_1122_3344_D000_0200) begin bad++;
      $display("FAIL wr_sram_line: got %h want d0000203d000020211223344d0000200", mem[2]); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_read_miss;
    int n; logic a, e; logic [31:0] d;
    drive_req(32'h24, 32'h0, 4'hF, 1'b0);
    @(posedge clk); #1;
    total++; if (sram_addr !== 7'd2 || sram_we !== 1'b0 || wb_ack !== 1'b0) begin bad++;
      $display("FAIL miss_issue: got addr=%h we=%b ack=%b want 2 0 0", sram_addr, sram_we, wb_ack); end
    wait_resp(n, a, e, d);
    total++; if (n !== 2 || a !== 1'b1) begin bad++;
      $display("FAIL miss_ack_latency: got extra edges=%0d ack=%b want 2 1", n, a); end
    total++; if (d !== 32'h1122_3344) begin bad++;
      $display("FAIL miss_data: got %h want 11223344", d); end
    @(posedge clk); #1;
    total++; if (wb_ack !== 1'b0) begin bad++;
      $display("FAIL miss_ack_one_cycle: got %b want 0", wb_ack); end
  endtask

  task automatic test_read_hit;
    int n; logic a, e; logic [31:0] d;
    drive_req(32'h28, 32'h0, 4'hF, 1'b0);
    wait_resp(n, a, e, d);
    total++; if (n !== 1 || a !== 1'b1) begin bad++;
      $display("FAIL hit_ack_latency: got n=%0d ack=%b want 1 1", n, a); end
    total++; if (d !== 32'hD000_0202) begin bad++;
      $display("FAIL hit_data: got %h want d0000202", d); end
    total++; if (sram_addr !== 7'd2 || sram_we !== 1'b0) begin bad++;
      $display("FAIL hit_sram_idle: got addr=%h we=%b want 2 0", sram_addr, sram_we); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_merge;
    int n; logic a, e; logic [31:0] d;
    drive_req(32'h26, 32'hAABB_0000, 4'hC, 1'b1);
    wait_resp(n, a, e, d);
    total++; if (n !== 1 || sram_be !== 16'h00C0) begin bad++;
      $display("FAIL merge_wr: got n=%0d be=%h want 1 00c0", n, sram_be); end
    @(posedge clk); #1;
    total++; if (mem[2][63:48] !== 16'hAABB) begin bad++;
      $display("FAIL merge_sram_bytes: got %h want aabb", mem[2][63:48]); end
    drive_req(32'h24, 32'h0, 4'hF, 1'b0);
    wait_resp(n, a, e, d);
    total++; if (n !== 1 || d !== 32'hAABB_3344) begin bad++;
      $display("FAIL merge_rd_hit: got n=%0d data=%h want 1 aabb3344", n, d); end
    @(posedge clk); #1;
  endtask

  task automatic test_error;
    int n; logic a, e; logic [31:0] d;
    drive_req(32'h800, 32'h0, 4'hF, 1'b0);
    wait_resp(n, a, e, d);
    total++; if (n !== 1 || e !== 1'b1 || a !== 1'b0) begin bad++;
      $display("FAIL err_rd: got n=%0d err=%b ack=%b want 1 1 0", n, e, a); end
    @(posedge clk); #1;
    total++; if (wb_err !== 1'b0) begin bad++;
      $display("FAIL err_one_cycle: got %b want 0", wb_err); end
    drive_req(32'h800, 32'hFFFF_FFFF, 4'hF, 1'b1);
    wait_resp(n, a, e, d);
    total++; if (e !== 1'b1 || a !== 1'b0 || sram_we !== 1'b0) begin bad++;
      $display("FAIL err_wr: got err=%b ack=%b we=%b want 1 0 0", e, a, sram_we); end
    @(posedge clk); #1;
    total++; if (mem[0] !== pat(0)) begin bad++;
      $display("FAIL err_no_write: got %h want %h", mem[0], pat(0)); end
    drive_req(32'h24, 32'h0, 4'hF, 1'b0);
    wait_resp(n, a, e, d);
    total++; if (n !== 1 || d !== 32'hAABB_3344) begin bad++;
      $display("FAIL err_buf_kept: got n=%0d data=%h want 1 aabb3344", n, d); end
    @(posedge clk); #1;
  endtask

  task automatic test_sel_zero;
    int n; logic a, e; logic [31:0] d;
    drive_req(32'h28, 32'h1234_5678, 4'h0, 1'b1);
    wait_resp(n, a, e, d);
    total++; if (n !== 1 || a !== 1'b1 || sram_be !== 16'h0) begin bad++;
      $display("FAIL sel0_wr: got n=%0d ack=%b be=%h want 1 1 0", n, a, sram_be); end
    @(posedge clk); #1;
    total++; if (mem[2][95:64] !== 32'hD000_0202) begin bad++;
      $display("FAIL sel0_sram: got %h want d0000202", mem[2][95:64]); end
    drive_req(32'h28, 32'h0, 4'hF, 1'b0);
    wait_resp(n, a, e, d);
    total++; if (n !== 1 || d !== 32'hD000_0202) begin bad++;
      $display("FAIL sel0_buf: got n=%0d data=%h want 1 d0000202", n, d); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    drive_req(32'h2C, 32'h0, 4'hF, 1'b0);
    @(posedge clk); #1;
    total++; if (wb_ack !== 1'b1 || wb_dat_r !== 32'hD000_0203) begin bad++;
      $display("FAIL b2b_first: got ack=%b data=%h want 1 d0000203", wb_ack, wb_dat_r); end
    wb_adr = 32'h20;
    @(posedge clk); #1;
    total++; if (wb_ack !== 1'b0) begin bad++;
      $display("FAIL b2b_gap: got ack=%b want 0", wb_ack); end
    @(posedge clk); #1;
    total++; if (wb_ack !== 1'b1 || wb_dat_r !== 32'hD000_0200) begin bad++;
      $display("FAIL b2b_second: got ack=%b data=%h want 1 d0000200", wb_ack, wb_dat_r); end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    total++; if (wb_ack !== 1'b0) begin bad++;
      $display("FAIL b2b_end: got ack=%b want 0", wb_ack); end
  endtask

  task automatic test_cyc_drop;
    int n; int acks; logic a, e; logic [31:0] d;
    acks = 0;
    drive_req(32'h60, 32'h0, 4'hF, 1'b0);
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (wb_ack) acks++;
    end
    total++; if (acks !== 0) begin bad++;
      $display("FAIL drop_no_ack: got %0d acks want 0", acks); end
    drive_req(32'h64, 32'h0, 4'hF, 1'b0);
    wait_resp(n, a, e, d);
    total++; if (n !== 1 || d !== 32'hD000_0601) begin bad++;
      $display("FAIL drop_buf_filled: got n=%0d data=%h want 1 d0000601", n, d); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int n; int acks; logic a, e; logic [31:0] d;
    acks = 0;
    drive_req(32'h50, 32'h0, 4'hF, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    total++; if ({wb_ack, wb_err, sram_we} !== 3'b000 || sram_addr !== 7'd0 || sram_be !== 16'h0 || wb_dat_r !== 32'h0) begin bad++;
      $display("FAIL rstmid_outputs: got flags=%b addr=%h be=%h dat=%h want all 0",
               {wb_ack, wb_err, sram_we}, sram_addr, sram_be, wb_dat_r); end
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (wb_ack) acks++;
    end
    total++; if (acks !== 0) begin bad++;
      $display("FAIL rstmid_no_ack: got %0d acks want 0", acks); end
    drive_req(32'h50, 32'h0, 4'hF, 1'b0);
    wait_resp(n, a, e, d);
    total++; if (n !== 3 || d !== 32'hD000_0500) begin bad++;
      $display("FAIL rstmid_miss: got n=%0d data=%h want 3 d0000500", n, d); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_miss();
    test_read_hit();
    test_write_merge();
    test_error();
    test_sel_zero();
    test_back_to_back();
    test_cyc_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
